// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. A 16-bit hex value is shown one digit at a time. Each digit is
// preceded by an all-anodes-off gap so the previous digit's segment pattern
// never ghosts onto the next one.
//
// Display data is double-buffered. A load goes into a staging register, and
// the displayed (shadow) copy only changes at a frame boundary. While idle it
// changes one cycle after the load.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = scan, 0 = display dark (takes effect one cycle after sampling)
//   value_in    hex value; digit k shows value_in[4k+3:4k], digit 0 = LS nibble
//   dp_in       per-digit decimal point request, 1 = lit
//   lzb_en      1 = leading-zero blanking on digits 3..1
//   load        1-cycle strobe capturing value_in/dp_in into staging
//   an_n        anode selects, active-low, one-hot-low or all ones
//   seg_n       segments {g,f,e,d,c,b,a}, active-low
//   dp_n        decimal point, active-low
//   frame_done  1-cycle pulse on the first cycle of every frame after the first
//   load_ack    1-cycle pulse when staged data becomes the displayed data

module seven_seg_scan_ctrl #(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        load,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done,
  output logic        load_ack
);

  // The tick counter only has to reach the longer of the two phases.
  localparam int unsigned MaxTicks = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_TICKS - 1);
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_TICKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  // Hex nibble to segment pattern {g..a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              en_q;

  logic [15:0]       staged_val_q, staged_val_d;
  logic [3:0]        staged_dp_q, staged_dp_d;
  logic              pending_q, pending_d;
  logic [15:0]       shadow_val_q, shadow_val_d;
  logic [3:0]        shadow_dp_q, shadow_dp_d;

  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_done_q, frame_done_d;
  logic              load_ack_q, load_ack_d;

  logic              blank_last;
  logic              drive_last;
  logic              boundary;
  logic              xfer;

  // ---------------------------------------------------------------------------
  // State register (all state and registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      staged_val_q <= 16'h0000;
      staged_dp_q  <= 4'h0;
      pending_q    <= 1'b0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      en_q         <= enable;
      staged_val_q <= staged_val_d;
      staged_dp_q  <= staged_dp_d;
      pending_q    <= pending_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: scan sequencing and load handshake
  // ---------------------------------------------------------------------------
  assign blank_last = (cnt_q == BlankLast);
  assign drive_last = (cnt_q == DigitLast);

  // Last DRIVE cycle of digit 3 while still enabled: the next edge starts a frame.
  assign boundary = en_q && (state_q == StDrive) && (idx_q == 2'd3) && drive_last;

  // A load arriving on the boundary cycle is transferred directly, so a
  // boundary transfers whenever there is either pending or fresh data.
  assign xfer = (boundary && (pending_q || load)) || ((state_q == StIdle) && pending_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (!en_q) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (blank_last) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (drive_last) begin
            state_d = StBlank;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    staged_val_d = staged_val_q;
    staged_dp_d  = staged_dp_q;
    pending_d    = pending_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;

    if (load) begin
      staged_val_d = value_in;
      staged_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    if (xfer) begin
      shadow_val_d = load ? value_in : staged_val_q;
      shadow_dp_d  = load ? dp_in    : staged_dp_q;
      pending_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state and next shadow so the registered
  // anode, segment and dp lines all change on the same edge as state/idx.
  // ---------------------------------------------------------------------------
  logic [3:0] nib;
  logic       lead_zero;

  always_comb begin
    nib       = shadow_val_d[{idx_d, 2'b00} +: 4];
    lead_zero = 1'b0;
    unique case (idx_d)
      2'd3:    lead_zero = (shadow_val_d[15:12] == 4'h0);
      2'd2:    lead_zero = (shadow_val_d[15:8] == 8'h00);
      2'd1:    lead_zero = (shadow_val_d[15:4] == 12'h000);
      default: lead_zero = 1'b0;
    endcase

    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = boundary;
    load_ack_d   = xfer;

    if (state_d == StDrive) begin
      an_d[idx_d] = 1'b0;
      // A blanked leading zero keeps its anode and decimal point.
      seg_d       = (lzb_en && lead_zero) ? 7'h7F : ~hex_to_seg(nib);
      dp_d        = ~shadow_dp_d[idx_d];
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign frame_done = frame_done_q;
  assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic        load;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;
  logic        load_ack;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan_ctrl #(
    .DIGIT_TICKS(4),
    .BLANK_TICKS(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .lzb_en     (lzb_en),
    .load       (load),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, " an_n"}, 32'(an_n), 32'hF);
    check({tag, " seg_n"}, 32'(seg_n), 32'h7F);
    check({tag, " dp_n"}, 32'(dp_n), 32'h1);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Entered while sampling the first BLANK cycle of a frame; leaves sampling
  // the first BLANK cycle of the next one. Loads fire before the edge ending
  // cycle la1 / la2 (0..19, -1 = none).
  task automatic run_frame(input string name, input logic [15:0] v, input logic [3:0] dp,
                           input logic lzb, input logic fd, input logic ack,
                           input int la1, input logic [15:0] lv1,
                           input int la2, input logic [15:0] lv2);
    lzb_en = lzb;
    for (int c = 0; c < 20; c++) begin
      int         d;
      int         ph;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [15:0] upper;
      string      t;
      d  = c / 5;
      ph = c % 5;
      t  = $sformatf("%s c%0d", name, c);
      if (ph == 0) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_an  = ~(4'(1 << d));
        upper = v >> (4 * d);
        if (lzb && d > 0 && upper == 16'h0) e_seg = 7'h7F;
        else e_seg = ~seg7(4'(v >> (4 * d)));
        e_dp  = ~dp[d];
      end
      check({t, " an_n"}, 32'(an_n), 32'(e_an));
      check({t, " seg_n"}, 32'(seg_n), 32'(e_seg));
      check({t, " dp_n"}, 32'(dp_n), 32'(e_dp));
      check({t, " frame_done"}, 32'(frame_done), 32'(c == 0 && fd));
      check({t, " load_ack"}, 32'(load_ack), 32'(c == 0 && ack));
      load = 1'b0;
      if (c == la1) begin
        load     = 1'b1;
        value_in = lv1;
      end
      if (c == la2) begin
        load     = 1'b1;
        value_in = lv2;
      end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    enable   = 1'b0;
    value_in = 16'h0;
    dp_in    = 4'h0;
    lzb_en   = 1'b0;
    load     = 1'b0;

    // Reset and idle
    #1 rst_n = 1'b0;
    #1;
    check_dark("reset");
    check("reset load_ack", 32'(load_ack), 32'h0);
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_dark($sformatf("idle%0d", i));
    end

    // Load in IDLE transfers on the following cycle
    value_in = 16'h1234;
    load     = 1'b1;
    tick();
    load = 1'b0;
    check("idle load ack early", 32'(load_ack), 32'h0);
    tick();
    check("idle load ack", 32'(load_ack), 32'h1);
    tick();
    check("idle load ack width", 32'(load_ack), 32'h0);

    // Enable sampled at E, BLANK from E+1
    enable = 1'b1;
    tick();
    check_dark("enable edge");
    tick();
    run_frame("f1", 16'h1234, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame("f2", 16'h1234, 4'h0, 1'b0, 1'b1, 1'b0, 5, 16'hABCD, 10, 16'hEF01);
    run_frame("f3", 16'hEF01, 4'h0, 1'b0, 1'b1, 1'b1, 19, 16'h5555, -1, 16'h0);
    run_frame("f4", 16'h5555, 4'h0, 1'b0, 1'b1, 1'b1, 3, 16'h0040, -1, 16'h0);
    dp_in = 4'b0100;
    run_frame("f5_lzb", 16'h0040, 4'h0, 1'b1, 1'b1, 1'b1, 3, 16'h0000, -1, 16'h0);
    run_frame("f6_lzb0", 16'h0000, 4'b0100, 1'b1, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame("f7_nolzb", 16'h0000, 4'b0100, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // Drop enable during DRIVE of digit 2
    for (int i = 0; i < 12; i++) tick();
    check("drop pre an_n", 32'(an_n), 32'hB);
    enable = 1'b0;
    tick();
    check("drop sample an_n", 32'(an_n), 32'hB);
    tick();
    check_dark("drop dark");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark($sformatf("drop idle%0d", i));
    end
    enable = 1'b1;
    tick();
    check_dark("reenable edge");
    tick();
    run_frame("f_restart", 16'h0000, 4'b0100, 1'b0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset mid-DRIVE
    tick();
    tick();
    check("pre reset an_n", 32'(an_n), 32'hE);
    #3 rst_n = 1'b0;
    #1;
    check_dark("async reset");
    check("async reset load_ack", 32'(load_ack), 32'h0);
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    check_dark("post reset enable edge");
    tick();
    run_frame("f_post_reset", 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a 16-bit hex value, walks the four digits in turn with a blanking gap between them to prevent ghosting, and drives active-low anode, segment and decimal-point lines. Display updates are double-buffered so the value only changes at a frame boundary. It sits between the system datapath and the board's display pins, and replaces per-digit static decoding.

## Interface
- `DIGIT_TICKS`, default 50000: clock cycles each digit is driven (DRIVE phase); must be ≥1.
- `BLANK_TICKS`, default 500: clock cycles with all anodes off before each digit (BLANK phase); must be ≥1.
- `clk` in 1: system clock. This is the block's single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: 1 = scan, 0 = display dark.
- `value_in` in 16: hex value; digit k shows `value_in[4k+3:4k]`, digit 0 = least significant.
- `dp_in` in 4: decimal point request per digit, 1 = lit.
- `lzb_en` in 1: 1 = leading-zero blanking on.
- `load` in 1: 1-cycle strobe; captures `value_in`/`dp_in` into the staging register.
- `an_n` out 4: anode select, active-low, one-hot-low or all 1.
- `seg_n` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n` out 1: decimal point, active-low.
- `frame_done` out 1: 1-cycle pulse at each frame boundary.
- `load_ack` out 1: 1-cycle pulse when staged data becomes the displayed data.

## Operation
- Registers: staged {value, dp} plus a pending flag; shadow {value, dp} (displayed); state; digit index 0..3; tick counter.
- States:
  - IDLE: all outputs dark.
  - BLANK: `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, for BLANK_TICKS cycles, then DRIVE.
  - DRIVE: `an_n[idx]`=0 with others 1, decoded segments, for DIGIT_TICKS cycles. From DRIVE the block goes to BLANK, with idx+1 mod 4.
- Transitions:
  - IDLE→BLANK with idx=0 when `enable`=1.
  - Any state→IDLE on the cycle after `enable` is sampled 0. On that transition idx and the tick counter clear.
- Segment encoding before inversion, in `{g..a}` order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking: with `lzb_en`=1, digit k∈{3,2,1} has `seg_n`=7'h7F if shadow nibbles k..3 are all zero. Digit 0 is never blanked. The anode is still driven. `dp_n` follows shadow dp regardless of blanking.
- Load handshake:
  - `load`=1 copies `value_in`/`dp_in` to staged and sets pending. A later load before the boundary overwrites staged.
  - At a frame boundary with pending=1: shadow←staged, pending clears, and `load_ack` pulses.
  - In IDLE, a pending load transfers on the next cycle, with a `load_ack` pulse.
  - `load` on the same cycle as a boundary transfer: the new `value_in` is the one transferred (staged bypass). Pending ends 0.
- Frame boundary: the cycle after the last DRIVE cycle of digit 3, i.e. the first BLANK cycle of digit 0.

## Timing
- Reset values:
  - outputs: `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0, `load_ack`=0
  - internal: state=IDLE, idx=0, shadow=0, staged=0, pending=0
- Reset assertion mid-scan forces the reset values immediately (asynchronous). The first `enable` after release starts at BLANK of digit 0.
- All outputs are registered. They take their new values on the same edge as the state/idx they belong to, so there is no cycle of skew between `an_n` and `seg_n`.
- `enable` sampled 1 at edge E: BLANK starts at E+1, and `an_n[0]` goes low at E+1+BLANK_TICKS.
- Frame period is 4×(BLANK_TICKS+DIGIT_TICKS) cycles.
- `frame_done` is high for exactly the first cycle of each frame after the first. Shadow update and `load_ack` coincide with it.
- Anodes are never low in two consecutive cycles for different digits. There is always at least one all-off cycle between digits.
- Counter widths are sized by `$clog2` of the larger parameter. There is no wrap beyond the parameter value.

## Test plan
Default benchmark parameters: DIGIT_TICKS=4, BLANK_TICKS=1, giving a 20-cycle frame.
- Reset/idle: hold `rst_n`=0, then release with `enable`=0 for 10 cycles → `an_n`=F, `seg_n`=7F, `dp_n`=1, `frame_done`=0 throughout.
- Basic scan: `load` 0x1234 in IDLE, then `enable`=1 → `load_ack` 1 cycle after load.
  - Each frame shows 1 cycle of `an_n`=F, then 4 cycles of `an_n`=E with `seg_n`=~66 (digit "4").
  - The rest of the frame continues D/~4F, B/~5B, 7/~06.
  - `frame_done` pulses every 20 cycles.
- Double-buffer: mid-frame load 0xABCD, then load 0xEF01 before the boundary → display stays 0x1234 until the boundary.
  - Next frame shows 0xEF01, with exactly one `load_ack`.
  - Also load 0x5555 on the last DRIVE cycle of digit 3 → the next frame shows 0x5555.
- Leading-zero blanking: 0x0040 with `lzb_en`=1 → digits 3 and 2 give `seg_n`=7F while their anodes still toggle. Digit 1 is "4", digit 0 is "0".
  - 0x0000 → only digit 0 lit ("0").
  - With `lzb_en`=0, all four digits are lit.
- Decimal point: `dp_in`=4'b0100 with 0x0000 and LZB on → digit 2 gives `seg_n`=7F, `dp_n`=0; the other digits give `dp_n`=1.
- Enable/reset mid-frame: drop `enable` during DRIVE of digit 2 → outputs dark the next cycle. Re-enable → restart at BLANK digit 0.
  - Assert `rst_n`=0 mid-DRIVE → outputs at reset values with no clock edge, and shadow=0.
